// File: rtl/rs232_tx_scheduler_pkg.sv
// Shared types and constants for the RS232 transmit scheduler and receive-side blocks.
// Holds the FSM state encoding, frame geometry, idle line level and the word-to-frame packer.
package rs232_tx_scheduler_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned TICKS_WORD = 2 * FRAME_BITS;
  localparam int unsigned CNT_W      = 5;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Two 8N1 frames, low byte first; bit 0 is the first bit on the line.
  function automatic logic [TICKS_WORD-1:0] frame_word(input word_t w);
    return {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
  endfunction

endpackage

// File: rtl/rs232_tx_scheduler_if.sv
// Bundle between user logic / clock generator and the transmit scheduler.
//   sync_i     link synchronised (level)
//   clk_send_i one-cycle bit tick from the clock generator
//   req_i      per-requester word pending, held until ack
//   data_i     word of requester k at [16k+15:16k]
//   ack_o      one-cycle pulse per completed word
//   dv_o       start pulse to the clock generator
//   tx_o       serial line, idle high
//   busy_o     word in flight (launch through shift)
//   grant_o    requester being served
interface rs232_tx_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDXW  = 2
);
  logic                  sync_i;
  logic                  clk_send_i;
  logic [N_REQ-1:0]      req_i;
  logic [16*N_REQ-1:0]   data_i;
  logic [N_REQ-1:0]      ack_o;
  logic                  dv_o;
  logic                  tx_o;
  logic                  busy_o;
  logic [IDXW-1:0]       grant_o;

  modport master (
    output sync_i, clk_send_i, req_i, data_i,
    input  ack_o, dv_o, tx_o, busy_o, grant_o
  );

  modport slave (
    input  sync_i, clk_send_i, req_i, data_i,
    output ack_o, dv_o, tx_o, busy_o, grant_o
  );
endinterface

// File: rtl/rs232_tx_scheduler_rr_arbiter_n.sv
// Round-robin pick: first set request at or after ptr, wrapping N_REQ-1 -> 0.
//   req   request vector
//   ptr   search start index
//   grant chosen index (0 when none)
//   any   at least one request set
module rr_arbiter_n #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDXW  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [IDXW-1:0]  grant,
  output logic             any
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx[IDXW-1:0]]) begin
        grant = IDXW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_scheduler.sv
// Shares one RS232 transmit path among N_REQ word requesters (round robin).
// Pulses dv_o to restart the clock generator, then shifts a 16-bit word out as
// two 8N1 frames on clk_send_i ticks. Transmits only while sync_i is held.
//   clk_ref    system clock
//   rst_global async active-low reset
//   bus        scheduler bundle (slave side)
module rs232_tx_scheduler
  import rs232_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDXW  = 2
) (
  input logic                  clk_ref,
  input logic                  rst_global,
  rs232_tx_scheduler_if.slave  bus
);

  state_e                state_q, state_d;
  logic [IDXW-1:0]       rr_q, rr_d;
  logic [IDXW-1:0]       grant_q, grant_d;
  logic [IDXW-1:0]       arb_grant;
  logic                  arb_any;
  logic [TICKS_WORD-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tx_q, tx_d;
  logic                  dv_q, dv_d;
  logic                  busy_q, busy_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic                  tick_shift;
  logic                  last_tick;
  word_t                 sel_word;

  rr_arbiter_n #(.N_REQ(N_REQ), .IDXW(IDXW)) u_arb (
    .req   (bus.req_i),
    .ptr   (rr_q),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign sel_word   = bus.data_i[WORD_W*arb_grant +: WORD_W];
  // Ticks only count inside SHIFT, so a tick coincident with dv_o (LAUNCH) is dropped.
  assign tick_shift = (state_q == ST_SHIFT) && bus.clk_send_i;
  assign last_tick  = tick_shift && (cnt_q == CNT_W'(TICKS_WORD - 1));

  // State register
  always_ff @(posedge clk_ref or negedge rst_global) begin
    if (!rst_global) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next state; losing sync anywhere in ARB..SHIFT abandons the word
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.sync_i) state_d = ST_ARB;
      ST_ARB:    if (!bus.sync_i) state_d = ST_IDLE;
                 else if (arb_any) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = bus.sync_i ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:  if (!bus.sync_i) state_d = ST_IDLE;
                 else if (last_tick) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    tx_d    = tx_q;
    dv_d    = 1'b0;
    busy_d  = (state_d == ST_LAUNCH) || (state_d == ST_SHIFT);
    ack_d   = '0;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rr_d    = rr_q;

    unique case (state_d)
      ST_LAUNCH: begin
        dv_d    = 1'b1;
        grant_d = arb_grant;
        sr_d    = frame_word(sel_word);
        tx_d    = sr_d[0];
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        if (tick_shift) begin
          sr_d  = sr_q >> 1;
          tx_d  = sr_q[1];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        tx_d           = IDLE_LEVEL;
        ack_d[grant_q] = 1'b1;
      end
      default: tx_d = IDLE_LEVEL;
    endcase

    // Pointer advances only on completion, so an aborted word keeps its turn
    if (state_q == ST_DONE) begin
      if (32'(grant_q) == N_REQ - 1) rr_d = '0;
      else                           rr_d = grant_q + IDXW'(1);
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk_ref or negedge rst_global) begin
    if (!rst_global) begin
      tx_q    <= IDLE_LEVEL;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      tx_q    <= tx_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.tx_o    = tx_q;
  assign bus.dv_o    = dv_q;
  assign bus.busy_o  = busy_q;
  assign bus.ack_o   = ack_q;
  assign bus.grant_o = grant_q;

endmodule
